// File: rtl/vmx_pkg.sv
// Shared definitions for the requantization stage.
//   - FSM state encodings used by vmx_requant_stage
//   - default widths used as parameter defaults
//   - saturation bounds as a function of the output width
package vmx_pkg;

    typedef enum logic [1:0] {
        REQ_IDLE  = 2'd0,
        REQ_RUN   = 2'd1,
        REQ_DRAIN = 2'd2,
        REQ_DONE  = 2'd3
    } req_state_t;

    localparam int DEF_PE_SIZE   = 4;
    localparam int DEF_ACC_WIDTH = 32;
    localparam int DEF_OUT_WIDTH = 16;
    localparam int DEF_SHIFT_W   = 5;

    // Largest value representable in a signed out_width-bit result.
    function automatic longint sat_max(input int out_width);
        return (longint'(1) <<< (out_width - 1)) - 1;
    endfunction

    // Smallest value representable in a signed out_width-bit result.
    function automatic longint sat_min(input int out_width);
        return -(longint'(1) <<< (out_width - 1));
    endfunction

endpackage

// File: rtl/vmx_requant_lane.sv
// Per-lane requantization datapath, three register stages:
//   S1: bias add at ACC_WIDTH+1 bits
//   S2: rounding arithmetic right shift (round half up) at ACC_WIDTH+2 bits
//   S3: optional ReLU, then saturation to OUT_WIDTH
// All stages advance together on en; they hold while en is low.
// Optional build macro VMX_REQUANT_STATS_EN adds the clip output.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   en          advance all stages
//   lane, bias  signed accumulator lane and bias
//   shift, relu requant configuration (stable during a job)
//   clip        (stats build only) value entering S3 is being saturated
//   res         S3 result register
module vmx_requant_lane
    import vmx_pkg::*;
#(
    parameter int ACC_WIDTH = DEF_ACC_WIDTH,
    parameter int OUT_WIDTH = DEF_OUT_WIDTH,
    parameter int SHIFT_W   = DEF_SHIFT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [ACC_WIDTH-1:0] lane,
    input  logic [ACC_WIDTH-1:0] bias,
    input  logic [SHIFT_W-1:0]   shift,
    input  logic                 relu,
`ifdef VMX_REQUANT_STATS_EN
    output logic                 clip,
`endif
    output logic [OUT_WIDTH-1:0] res
);

    localparam int RW = ACC_WIDTH + 2;
    localparam logic signed [RW-1:0] MAX_V = RW'(sat_max(OUT_WIDTH));
    localparam logic signed [RW-1:0] MIN_V = RW'(sat_min(OUT_WIDTH));

    logic [ACC_WIDTH:0]     sum_d;
    logic [ACC_WIDTH:0]     s1_q;
    logic signed [RW-1:0]   ext;
    logic signed [RW-1:0]   half;
    logic signed [RW-1:0]   rnd;
    logic signed [RW-1:0]   r_d;
    logic signed [RW-1:0]   s2_q;
    logic signed [RW-1:0]   relu_v;
    logic                   hi;
    logic                   lo;
    logic [OUT_WIDTH-1:0]   sat_d;

    always_comb begin
        sum_d = {lane[ACC_WIDTH-1], lane} + {bias[ACC_WIDTH-1], bias};
    end

    // The extra bit over S1 leaves room for the rounding constant.
    always_comb begin
        ext  = {s1_q[ACC_WIDTH], s1_q};
        half = '0;
        rnd  = ext;
        r_d  = ext;
        if (shift != '0) begin
            half = RW'(1) << (shift - SHIFT_W'(1));
            rnd  = ext + half;
            r_d  = rnd >>> shift;
        end
    end

    always_comb begin
        relu_v = s2_q;
        if (relu && s2_q[RW-1]) begin
            relu_v = '0;
        end
        hi    = (relu_v > MAX_V);
        lo    = (relu_v < MIN_V);
        sat_d = relu_v[OUT_WIDTH-1:0];
        if (hi) begin
            sat_d = MAX_V[OUT_WIDTH-1:0];
        end else if (lo) begin
            sat_d = MIN_V[OUT_WIDTH-1:0];
        end
    end

`ifdef VMX_REQUANT_STATS_EN
    assign clip = hi | lo;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
            s2_q <= '0;
            res  <= '0;
        end else if (en) begin
            s1_q <= sum_d;
            s2_q <= r_d;
            res  <= sat_d;
        end
    end

endmodule

// File: rtl/vmx_requant_stage.sv
// Requantization stage after the systolic array. Each accepted beat carries
// PE_SIZE accumulator lanes plus an address; every lane gets bias add,
// rounding right shift, optional ReLU and saturation. Results leave through
// a valid/ready port three cycles after acceptance when not stalled.
// A job of cfg_len beats is armed by a start pulse in IDLE.
// Optional build macro: VMX_REQUANT_STATS_EN enables the saturated-lane
// counter sat_count; without it sat_count is tied to zero.
// Ports:
//   clk, rst_n               clock, async active-low reset
//   start, cfg_*             job arm pulse and config sampled with it
//   in_valid/in_ready        input beat handshake, in_addr/in_data payload
//   out_valid/out_ready      output beat handshake, out_addr/out_data payload
//   busy, done               job in progress / one-cycle completion pulse
//   sat_count                lanes saturated since last accepted start
//
// state     | meaning
// ----------+-----------------------------------------------------------
// REQ_IDLE  | waiting for start; config latched on start
// REQ_RUN   | accepting beats until cfg_len have been taken
// REQ_DRAIN | no more input; waiting for pipeline and output to empty
// REQ_DONE  | done pulse for one cycle, back to idle
module vmx_requant_stage
    import vmx_pkg::*;
#(
    parameter int PE_SIZE   = DEF_PE_SIZE,
    parameter int ACC_WIDTH = DEF_ACC_WIDTH,
    parameter int OUT_WIDTH = DEF_OUT_WIDTH,
    parameter int SHIFT_W   = DEF_SHIFT_W
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [7:0]                     cfg_len,
    input  logic [SHIFT_W-1:0]             cfg_shift,
    input  logic [ACC_WIDTH-1:0]           cfg_bias,
    input  logic                           cfg_relu,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [7:0]                     in_addr,
    input  logic [PE_SIZE*ACC_WIDTH-1:0]   in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [7:0]                     out_addr,
    output logic [PE_SIZE*OUT_WIDTH-1:0]   out_data,
    output logic                           busy,
    output logic                           done,
    output logic [15:0]                    sat_count
);

    req_state_t             state_q;
    req_state_t             state_d;
    logic [7:0]             len_q;
    logic [7:0]             cnt_q;
    logic [SHIFT_W-1:0]     shift_q;
    logic [ACC_WIDTH-1:0]   bias_q;
    logic                   relu_q;
    logic                   s1_v;
    logic                   s2_v;
    logic [7:0]             a1_q;
    logic [7:0]             a2_q;
    logic                   stall;
    logic                   adv;
    logic                   in_fire;
    logic                   start_acc;
    logic                   pipe_empty;

    assign stall      = out_valid & ~out_ready;
    assign adv        = ~stall;
    assign in_ready   = (state_q == REQ_RUN) && (cnt_q < len_q) && !stall;
    assign in_fire    = in_valid & in_ready;
    assign start_acc  = start && (state_q == REQ_IDLE);
    assign pipe_empty = !s1_v && !s2_v && !out_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= REQ_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            REQ_IDLE: begin
                if (start) begin
                    state_d = (cfg_len == 8'd0) ? REQ_DONE : REQ_RUN;
                end
            end
            REQ_RUN: begin
                busy = 1'b1;
                if (in_fire && (cnt_q + 8'd1 == len_q)) begin
                    state_d = REQ_DRAIN;
                end
            end
            REQ_DRAIN: begin
                busy = 1'b1;
                if (pipe_empty) begin
                    state_d = REQ_DONE;
                end
            end
            REQ_DONE: begin
                done    = 1'b1;
                state_d = REQ_IDLE;
            end
            default: state_d = REQ_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q   <= '0;
            cnt_q   <= '0;
            shift_q <= '0;
            bias_q  <= '0;
            relu_q  <= 1'b0;
        end else if (start_acc) begin
            len_q   <= cfg_len;
            cnt_q   <= '0;
            shift_q <= cfg_shift;
            bias_q  <= cfg_bias;
            relu_q  <= cfg_relu;
        end else if (in_fire) begin
            cnt_q   <= cnt_q + 8'd1;
        end
    end

    // Valid bits and addresses move in lockstep with the lane datapath;
    // the last stage doubles as the output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v      <= 1'b0;
            s2_v      <= 1'b0;
            out_valid <= 1'b0;
            a1_q      <= '0;
            a2_q      <= '0;
            out_addr  <= '0;
        end else if (adv) begin
            s1_v      <= in_fire;
            s2_v      <= s1_v;
            out_valid <= s2_v;
            a1_q      <= in_addr;
            a2_q      <= a1_q;
            out_addr  <= a2_q;
        end
    end

`ifdef VMX_REQUANT_STATS_EN
    logic [PE_SIZE-1:0] clip_vec;
`endif

    for (genvar g = 0; g < PE_SIZE; g++) begin : g_lane
        vmx_requant_lane #(
            .ACC_WIDTH (ACC_WIDTH),
            .OUT_WIDTH (OUT_WIDTH),
            .SHIFT_W   (SHIFT_W)
        ) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (adv),
            .lane  (in_data[g*ACC_WIDTH +: ACC_WIDTH]),
            .bias  (bias_q),
            .shift (shift_q),
            .relu  (relu_q),
`ifdef VMX_REQUANT_STATS_EN
            .clip  (clip_vec[g]),
`endif
            .res   (out_data[g*OUT_WIDTH +: OUT_WIDTH])
        );
    end

`ifdef VMX_REQUANT_STATS_EN
    logic [15:0] sat_q;
    logic [16:0] sat_sum;

    // Clip flags describe the beat entering S3, so count only when a valid
    // beat actually moves into S3.
    always_comb begin
        sat_sum = {1'b0, sat_q} + 17'($countones(clip_vec));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_q <= '0;
        end else if (start_acc) begin
            sat_q <= '0;
        end else if (adv && s2_v) begin
            sat_q <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
        end
    end

    assign sat_count = sat_q;
`else
    assign sat_count = '0;
`endif

endmodule

// File: tb/tb_vmx_requant_stage.sv
`timescale 1ns/1ps
module tb_vmx_requant_stage;

    localparam int PE = 4;
    localparam int AW = 32;
    localparam int OW = 16;
    localparam int SW = 5;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [7:0]        cfg_len = '0;
    logic [SW-1:0]     cfg_shift = '0;
    logic [AW-1:0]     cfg_bias = '0;
    logic              cfg_relu = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [7:0]        in_addr = '0;
    logic [PE*AW-1:0]  in_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [7:0]        out_addr;
    logic [PE*OW-1:0]  out_data;
    logic              busy;
    logic              done;
    logic [15:0]       sat_count;

    always #5 clk = ~clk;

    vmx_requant_stage #(
        .PE_SIZE(PE), .ACC_WIDTH(AW), .OUT_WIDTH(OW), .SHIFT_W(SW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_len(cfg_len),
        .cfg_shift(cfg_shift), .cfg_bias(cfg_bias), .cfg_relu(cfg_relu),
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_data(out_data), .busy(busy), .done(done),
        .sat_count(sat_count)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int m_shift = 0;
    int m_bias = 0;
    bit m_relu = 0;
    int exp_sat = 0;

    function automatic int ref_lane(input int lane, input int bias, input int shift,
                                    input bit relu, output bit clip);
        longint s;
        s = longint'(lane) + longint'(bias);
        if (shift != 0) s = (s + (longint'(1) <<< (shift - 1))) >>> shift;
        if (relu && s < 0) s = 0;
        clip = 1'b0;
        if (s > 32767) begin s = 32767; clip = 1'b1; end
        else if (s < -32768) begin s = -32768; clip = 1'b1; end
        return int'(s);
    endfunction

    function automatic void ref_beat(input logic [PE*AW-1:0] d,
                                     output logic [PE*OW-1:0] o, output int clips);
        bit c;
        int v;
        clips = 0;
        o = '0;
        for (int k = 0; k < PE; k++) begin
            v = ref_lane(int'($signed(d[k*AW +: AW])), m_bias, m_shift, m_relu, c);
            o[k*OW +: OW] = 16'(v);
            if (c) clips++;
        end
    endfunction

    function automatic int exp_sat_val();
`ifdef VMX_REQUANT_STATS_EN
        return exp_sat;
`else
        return 0;
`endif
    endfunction

    typedef struct {
        logic [7:0]       addr;
        logic [PE*OW-1:0] data;
    } exp_t;
    exp_t sb_q[$];

    int n_acc = 0;
    int n_out = 0;
    int n_done = 0;
    int done0 = 0;

    // Scoreboard / protocol monitor, sampling at the falling edge.
    bit               prev_stall = 0;
    logic [PE*OW-1:0] prev_data;
    logic [7:0]       prev_addr;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 0;
            end else begin
                if (prev_stall) begin
                    chk("hold_valid", 64'(out_valid), 1);
                    chk("hold_data", 64'(out_data), 64'(prev_data));
                    chk("hold_addr", 64'(out_addr), 64'(prev_addr));
                end
                if (out_valid && !out_ready) chk("in_ready_stall", 64'(in_ready), 0);
                if (in_valid && in_ready) begin
                    exp_t e;
                    int cl;
                    e.addr = in_addr;
                    ref_beat(in_data, e.data, cl);
                    sb_q.push_back(e);
                    exp_sat = (exp_sat + cl > 65535) ? 65535 : exp_sat + cl;
                    n_acc++;
                end
                if (out_valid && out_ready) begin
                    chk("sb_nonempty", 64'(sb_q.size() > 0), 1);
                    if (sb_q.size() > 0) begin
                        exp_t e;
                        e = sb_q.pop_front();
                        chk("sb_data", 64'(out_data), 64'(e.data));
                        chk("sb_addr", 64'(out_addr), 64'(e.addr));
                    end
                    n_out++;
                end
                if (done) n_done++;
                prev_stall = out_valid && !out_ready;
                prev_data  = out_data;
                prev_addr  = out_addr;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    // ---------------- stimulus helpers ----------------
    task automatic next_drive();
        @(posedge clk);
        #1;
    endtask

    // Called at a drive point with the DUT idle.
    task automatic start_job(input int len, input int shift, input int bias, input bit relu);
        cfg_len = 8'(len);
        cfg_shift = SW'(shift);
        cfg_bias = bias;
        cfg_relu = relu;
        start = 1'b1;
        m_shift = shift;
        m_bias = bias;
        m_relu = relu;
        exp_sat = 0;
        done0 = n_done;
        next_drive();
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        bit fin = 0;
        for (int k = 0; k < budget && !fin; k++) begin
            @(negedge clk);
            if ((n_done != done0) && !done && !busy) fin = 1;
        end
        chk({name, "_done_pulses"}, 64'(n_done - done0), 1);
        chk({name, "_idle"}, 64'(fin), 1);
        chk({name, "_sat"}, 64'(sat_count), 64'(exp_sat_val()));
        next_drive();
    endtask

    function automatic logic [PE*AW-1:0] rand_data();
        logic [PE*AW-1:0] d;
        int v;
        for (int k = 0; k < PE; k++) begin
            case ($urandom_range(0, 2))
                0: v = int'($urandom);
                1: v = int'($urandom_range(0, 200000)) - 100000;
                default: v = int'($urandom_range(0, 2000)) - 1000;
            endcase
            d[k*AW +: AW] = v;
        end
        return d;
    endfunction

    typedef struct {
        int lane[4];
        int bias;
        int shift;
        bit relu;
        int exp[4];
        int clips;
    } vec_t;
    vec_t tbl[6];

    task automatic run_vec(input int i);
        int lat;
        start_job(1, tbl[i].shift, tbl[i].bias, tbl[i].relu);
        in_valid = 1'b1;
        in_addr = 8'(i + 16);
        for (int k = 0; k < PE; k++) in_data[k*AW +: AW] = tbl[i].lane[k];
        @(negedge clk);
        chk("vec_in_ready", 64'(in_ready), 1);
        next_drive();
        in_valid = 1'b0;
        lat = 0;
        for (int k = 1; k <= 8 && lat == 0; k++) begin
            @(negedge clk);
            if (out_valid) lat = k;
        end
        chk("vec_latency", 64'(lat), 3);
        for (int k = 0; k < PE; k++)
            chk($sformatf("vec%0d_lane%0d", i, k), 64'($signed(out_data[k*OW +: OW])), 64'(tbl[i].exp[k]));
        chk("vec_addr", 64'(out_addr), 64'(i + 16));
        next_drive();
        wait_idle("vec", 12);
`ifdef VMX_REQUANT_STATS_EN
        chk("vec_table_sat", 64'(sat_count), 64'(tbl[i].clips));
`else
        chk("vec_table_sat", 64'(sat_count), 0);
`endif
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int sent;
        int o0;
        bit fire;

        tbl[0] = '{lane:'{100, -100, 8, -8}, bias:0, shift:4, relu:1'b0,
                   exp:'{6, -6, 1, 0}, clips:0};
        tbl[1] = '{lane:'{40000, -5000, 0, 32767}, bias:1000, shift:0, relu:1'b1,
                   exp:'{32767, 0, 1000, 32767}, clips:2};
        tbl[2] = '{lane:'{-40000, 65535, -1, 1}, bias:0, shift:1, relu:1'b0,
                   exp:'{-20000, 32767, 0, 1}, clips:1};
        tbl[3] = '{lane:'{2147483647, int'(32'h8000_0000), 3, -3}, bias:-1, shift:31, relu:1'b0,
                   exp:'{1, -1, 0, 0}, clips:0};
        tbl[4] = '{lane:'{0, 100000, 200000, -50000}, bias:-100000, shift:2, relu:1'b0,
                   exp:'{-25000, 0, 25000, -32768}, clips:1};
        tbl[5] = '{lane:'{-1, -2, -3, 5}, bias:0, shift:1, relu:1'b1,
                   exp:'{0, 0, 0, 3}, clips:0};

        // Reset values
        #12;
        chk("rst_in_ready", 64'(in_ready), 0);
        chk("rst_out_valid", 64'(out_valid), 0);
        chk("rst_out_addr", 64'(out_addr), 0);
        chk("rst_out_data", 64'(out_data), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_done", 64'(done), 0);
        chk("rst_sat", 64'(sat_count), 0);
        next_drive();
        rst_n = 1'b1;
        next_drive();

        // Table-driven single-beat jobs
        for (int i = 0; i < 6; i++) run_vec(i);

        // Backpressure: 8 streaming beats, sink stalls cycles 4..7
        start_job(8, int'($urandom_range(0, 31)), int'($urandom_range(0, 4000)) - 2000,
                  1'($urandom_range(0, 1)));
        o0 = n_out;
        sent = 0;
        for (int cyc = 0; cyc < 60 && (n_out - o0) < 8; cyc++) begin
            out_ready = !(cyc >= 4 && cyc <= 7);
            in_valid = (sent < 8);
            in_addr = 8'(sent);
            in_data = rand_data();
            @(negedge clk);
            fire = in_valid && in_ready;
            if (cyc >= 4 && cyc <= 7) chk("bp_in_ready_low", 64'(in_ready), 0);
            next_drive();
            if (fire) sent++;
        end
        out_ready = 1'b1;
        in_valid = 1'b0;
        chk("bp_sent", 64'(sent), 8);
        chk("bp_outs", 64'(n_out - o0), 8);
        wait_idle("bp", 20);

        // Length boundary: valid held for 6 cycles, only 3 taken
        start_job(3, 2, 0, 0);
        sent = 0;
        for (int c = 0; c < 6; c++) begin
            in_valid = 1'b1;
            in_addr = 8'(sent + 32);
            in_data = rand_data();
            @(negedge clk);
            fire = in_valid && in_ready;
            if (c >= 3) chk("len_in_ready_low", 64'(in_ready), 0);
            next_drive();
            if (fire) sent++;
        end
        in_valid = 1'b0;
        chk("len_accepted", 64'(sent), 3);
        wait_idle("len", 20);

        // Zero length
        o0 = n_out;
        start_job(0, 3, 5, 0);
        @(negedge clk);
        chk("zl_done", 64'(done), 1);
        chk("zl_busy", 64'(busy), 0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("zl_done_low", 64'(done), 0);
            chk("zl_no_out", 64'(out_valid), 0);
        end
        chk("zl_outs", 64'(n_out - o0), 0);
        next_drive();

        // Start during RUN is ignored
        start_job(2, 3, 50, 0);
        in_valid = 1'b1;
        in_addr = 8'd40;
        in_data = rand_data();
        @(negedge clk);
        chk("ign_in_ready0", 64'(in_ready), 1);
        next_drive();
        in_valid = 1'b0;
        cfg_len = 8'd5;
        cfg_shift = SW'(0);
        cfg_bias = -7777;
        cfg_relu = 1'b1;
        start = 1'b1;
        @(negedge clk);
        chk("ign_busy", 64'(busy), 1);
        next_drive();
        start = 1'b0;
        in_valid = 1'b1;
        in_addr = 8'd41;
        in_data = rand_data();
        @(negedge clk);
        chk("ign_in_ready1", 64'(in_ready), 1);
        next_drive();
        @(negedge clk);
        chk("ign_len_kept", 64'(in_ready), 0);
        next_drive();
        in_valid = 1'b0;
        wait_idle("ign", 20);

        // Async reset in the middle of a 4-beat job
        start_job(4, 1, 0, 0);
        in_valid = 1'b1;
        in_addr = 8'd50;
        in_data = rand_data();
        next_drive();
        in_addr = 8'd51;
        in_data = rand_data();
        #2;
        rst_n = 1'b0;
        #1;
        in_valid = 1'b0;
        chk("arst_in_ready", 64'(in_ready), 0);
        chk("arst_out_valid", 64'(out_valid), 0);
        chk("arst_out_addr", 64'(out_addr), 0);
        chk("arst_out_data", 64'(out_data), 0);
        chk("arst_busy", 64'(busy), 0);
        chk("arst_done", 64'(done), 0);
        chk("arst_sat", 64'(sat_count), 0);
        next_drive();
        next_drive();
        rst_n = 1'b1;
        sb_q.delete();
        done0 = n_done;
        for (int c = 0; c < 6; c++) @(negedge clk);
        chk("arst_no_done", 64'(n_done - done0), 0);
        chk("arst_idle", 64'(busy), 0);
        next_drive();
        run_vec(0);
        run_vec(4);

        // Randomized jobs with bubbles and random backpressure
        for (int j = 0; j < 12; j++) begin
            int len;
            len = int'($urandom_range(1, 12));
            start_job(len, int'($urandom_range(0, 31)),
                      int'($urandom_range(0, 200000)) - 100000, 1'($urandom_range(0, 1)));
            o0 = n_out;
            sent = 0;
            for (int cyc = 0; cyc < 300 && (n_out - o0) < len; cyc++) begin
                out_ready = ($urandom_range(0, 9) < 7);
                in_valid = (sent < len) && ($urandom_range(0, 9) < 7);
                in_addr = 8'($urandom);
                in_data = rand_data();
                @(negedge clk);
                fire = in_valid && in_ready;
                next_drive();
                if (fire) sent++;
            end
            out_ready = 1'b1;
            in_valid = 1'b0;
            chk("rnd_sent", 64'(sent), 64'(len));
            chk("rnd_outs", 64'(n_out - o0), 64'(len));
            wait_idle("rnd", 20);
        end

        chk("final_sb_empty", 64'(sb_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
